an_encoder_seq: RTL and testbench

- Transmit-side counterpart of the A=37 AN-code decoder: computes codeword = A × message.
- Uses a multi-cycle shift-and-add multiplier, iterating over the bits of A, with valid/ready handshakes on input and output.
- Sits ahead of the channel/storage path. Its codewords are what the Barrett-residue + AN-decoder chain later corrects.
- Flags messages whose product does not fit in the codeword width the decoder accepts.

---
 rtl/an_code_pkg.sv | 35 +++
 rtl/an_encoder_seq.sv | 86 ++++++++
 tb/tb_an_encoder_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/an_code_pkg.sv
// Shared AN-code (A=37) constants, FSM state type and the decoder's +/-2^i residue table,
// so the encoder and decoder always agree on A.
package an_code_pkg;

  localparam int A       = 37;
  localparam int AW      = 6;
  localparam int MW      = 13;
  localparam int CW      = 18;
  localparam int PW      = MW + AW;
  localparam int MAX_MSG = (2**CW - 1) / A;
  localparam int CNTW    = $clog2(AW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Entries [0..CW-1] hold +2^i mod A, entries [CW..2*CW-1] hold -2^i mod A.
  typedef logic [2*CW-1:0][AW-1:0] err_table_t;

  function automatic err_table_t gen_err_table();
    err_table_t t;
    int         r;
    for (int i = 0; i < CW; i++) begin
      r          = (1 << i) % A;
      t[i]       = AW'(r);
      t[CW + i]  = AW'((A - r) % A);
    end
    return t;
  endfunction

  localparam err_table_t ERR_TABLE = gen_err_table();

endpackage

// File: rtl/an_encoder_seq.sv
// AN encoder: codeword = 37 * message by shift-and-add; out_valid appears AW edges after the accept edge.
// Accepts only in IDLE; a pending codeword is held in DONE for as long as out_ready stays low.
module an_encoder_seq
  import an_code_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] message,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] codeword,
  output logic          ovf
);

  localparam logic [AW-1:0] A_BITS = AW'(A);

  state_e          state;
  state_e          state_nxt;
  logic [PW-1:0]   mreg;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nxt;
  logic [CNTW-1:0] cnt;
  logic            last;

  assign last = (cnt == CNTW'(AW - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_nxt   = A_BITS[cnt] ? (acc + mreg) : acc;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accumulator is PW bits wide so the full product never wraps; ovf looks above CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      codeword <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mreg <= {{AW{1'b0}}, message};
            acc  <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          acc  <= acc_nxt;
          mreg <= mreg << 1;
          cnt  <= cnt + CNTW'(1);
          if (last) begin
            codeword <= acc_nxt[CW-1:0];
            ovf      <= |acc_nxt[PW-1:CW];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Directed bench for an_encoder_seq: expected codewords come from A*message arithmetic,
// queued at acceptance and compared when the encoder presents them.
module tb_an_encoder_seq;
  import an_code_pkg::*;

  typedef struct packed {
    logic [CW-1:0] cw;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] message;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] codeword;
  logic          ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  an_encoder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .message   (message),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeword  (codeword),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int msg);
    exp_t e;
    int   prod;
    prod  = msg * 37;
    e.cw  = CW'(prod % (1 << CW));
    e.ovf = (msg > 7084);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents msg, returns #1 after the accepting edge with the operand scrambled.
  task automatic send(input int msg);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    message  = MW'(msg);
    in_valid = 1'b1;
    sb.push_back(model(msg));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    message  = MW'($urandom);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  // Edges counted including the accepting edge.
  task automatic wait_out(output int edges);
    edges = 1;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
      if (!out_valid) check("in_ready_busy", 32'(in_ready), 32'd0);
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_cw"}, 32'(codeword), 32'(e.cw));
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_one(input string tag, input int msg, input bit chk_lat);
    int edges;
    send(msg);
    wait_out(edges);
    if (chk_lat) check({tag, "_latency"}, 32'(edges), 32'(AW + 1));
    pop_check(tag);
    handshake(tag);
  endtask

  initial begin
    int edges;
    int accepts;
    int outs;
    int msg;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    message   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_codeword", 32'(codeword), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ignored when in_valid is low.
    message = 13'd99;
    repeat (3) @(negedge clk);
    check("idle_no_accept", 32'(in_ready), 32'd1);
    check("idle_no_out", 32'(out_valid), 32'd0);

    run_one("msg1", 1, 1'b1);
    run_one("msg7084", 7084, 1'b1);
    run_one("msg7085", 7085, 1'b1);
    run_one("msg8191", 8191, 1'b1);
    run_one("msg0", 0, 1'b1);

    // Backpressure: codeword held for 20 cycles.
    out_ready = 1'b0;
    send(100);
    wait_out(edges);
    pop_check("bp");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_codeword", 32'(codeword), 32'd3700);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    handshake("bp");

    // Reset during the third BUSY cycle.
    send(50);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_codeword", 32'(codeword), 32'd0);
    void'(sb.pop_back());
    repeat (10) begin
      @(posedge clk);
      #1;
      check("midrst_no_out", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_one("after_rst", 2, 1'b1);

    // Sweep of non-overflow messages: decoder round trip with residue 0.
    for (int i = 0; i < 12; i++) begin
      msg = (i == 0) ? 7084 : int'($urandom_range(0, 7084));
      send(msg);
      wait_out(edges);
      check("sweep_residue", 32'(codeword % 37), 32'd0);
      check("sweep_decode", 32'(codeword / 37), 32'(msg));
      pop_check("sweep");
      handshake("sweep");
    end

    // Back-to-back in_valid: one acceptance per IDLE visit.
    accepts = 0;
    outs    = 0;
    @(negedge clk);
    in_valid = 1'b1;
    message  = 13'd5;
    for (int i = 0; i < 24; i++) begin
      if (in_valid && in_ready) begin
        accepts++;
        sb.push_back(model(5));
      end
      if (out_valid && out_ready) begin
        outs++;
        pop_check("b2b");
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    check("b2b_outputs", 32'(outs), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
